// File: rtl/rs_driver_pkg.sv
// rtl/rs_driver_pkg.sv - shared state encoding and default timing for the RS latch driver
package rs_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE,
        ST_CHECK
    } state_t;

    localparam int DEF_PULSE_W = 2;
    localparam int DEF_SETTLE  = 1;
    localparam int DEF_MAX_TRY = 3;

endpackage

// File: rtl/rs_pulse_timer.sv
// rtl/rs_pulse_timer.sv - loadable down-counter timing the pulse and settle phases
module rs_pulse_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/rs_driver.sv
// rtl/rs_driver.sv - pulses a gated RS latch and confirms the write through Q feedback
module rs_driver
    import rs_driver_pkg::*;
#(
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int MAX_TRY = DEF_MAX_TRY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic Q_fb,
    output logic done,
    output logic err,
    output logic level
);

    // Timer loads are count-1 because the phase ends on the cycle the counter reads zero.
    localparam logic [3:0] PW_LOAD  = 4'(PULSE_W - 1);
    localparam logic [3:0] ST_LOAD  = 4'(SETTLE - 1);
    localparam logic [2:0] TRY_LIM  = 3'(MAX_TRY);

    state_t     state, state_nxt;
    logic [2:0] tries, tries_nxt;
    logic       cap_level, cap_nxt;
    logic       done_nxt, err_nxt, level_nxt;
    logic       s_nxt, r_nxt;
    logic       tmr_load, tmr_zero;
    logic [3:0] tmr_val;

    rs_pulse_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        tries_nxt = tries;
        cap_nxt   = cap_level;
        tmr_load  = 1'b0;
        tmr_val   = 4'd0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        level_nxt = level;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt = ST_PULSE;
                    cap_nxt   = req_level;
                    tries_nxt = 3'd0;
                    tmr_load  = 1'b1;
                    tmr_val   = PW_LOAD;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    if (SETTLE == 0) begin
                        state_nxt = ST_CHECK;
                    end else begin
                        state_nxt = ST_SETTLE;
                        tmr_load  = 1'b1;
                        tmr_val   = ST_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (Q_fb == cap_level) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    level_nxt = cap_level;
                end else begin
                    tries_nxt = tries + 3'd1;
                    if (tries_nxt < TRY_LIM) begin
                        state_nxt = ST_PULSE;
                        tmr_load  = 1'b1;
                        tmr_val   = PW_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // S and R are decoded from one level bit, so they can never be high together.
        s_nxt = (state_nxt == ST_PULSE) && cap_nxt;
        r_nxt = (state_nxt == ST_PULSE) && !cap_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tries     <= 3'd0;
            cap_level <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            level     <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            tries     <= tries_nxt;
            cap_level <= cap_nxt;
            S         <= s_nxt;
            R         <= r_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            level     <= level_nxt;
            req_ready <= (state_nxt == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_rs_driver.sv
// tb/tb_rs_driver.sv - randomized self-checking bench for rs_driver against a transaction-level latch model
module tb_rs_driver;

    localparam int PW  = 2;
    localparam int ST  = 1;
    localparam int MT  = 3;
    localparam int ATTEMPT_CYC = PW + ST + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid;
    logic req_level;
    logic req_ready;
    logic S, R;
    logic Q_fb;
    logic done, err, level;

    logic q_latch = 1'b0;
    int   pulse_seen = 0;
    int   nbad_cur = 0;
    logic level_m = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    rs_driver #(.PULSE_W(PW), .SETTLE(ST), .MAX_TRY(MT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_level (req_level),
        .req_ready (req_ready),
        .S         (S),
        .R         (R),
        .Q_fb      (Q_fb),
        .done      (done),
        .err       (err),
        .level     (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (S) q_latch <= 1'b1;
        else if (R) q_latch <= 1'b0;
    end

    // The first nbad_cur checks see the latch inverted, emulating a stuck or weak write.
    assign Q_fb = (pulse_seen <= nbad_cur) ? ~q_latch : q_latch;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) chk("ready_wait", req_ready, 1);
    endtask

    task automatic run_txn(input logic lvl, input int nbad);
        int cycles = 0, s_cyc = 0, r_cyc = 0, n_done = 0, n_err = 0;
        int both_sr = 0, both_de = 0, extra = 0, exp_p;
        logic prev = 1'b0;
        bit ok;
        wait_ready();
        nbad_cur   = nbad;
        pulse_seen = 0;
        req_valid  = 1'b1;
        req_level  = lvl;
        while (cycles < 60) begin
            @(negedge clk);
            cycles++;
            req_level = 1'($urandom);
            if (S && R) both_sr++;
            if (done && err) both_de++;
            if (S) s_cyc++;
            if (R) r_cyc++;
            if ((S || R) && !prev) pulse_seen++;
            prev = S || R;
            if (done) n_done++;
            if (err) n_err++;
            if (done || err) break;
            if (req_valid && req_ready) extra++;
        end
        req_valid = 1'b0;
        ok    = (nbad < MT);
        exp_p = ok ? nbad + 1 : MT;
        if (ok) level_m = lvl;
        chk("latency", cycles, ATTEMPT_CYC * exp_p + 1);
        chk("pulses", pulse_seen, exp_p);
        chk("s_cycles", s_cyc, lvl ? PW * exp_p : 0);
        chk("r_cycles", r_cyc, lvl ? 0 : PW * exp_p);
        chk("done", n_done, ok ? 1 : 0);
        chk("err", n_err, ok ? 0 : 1);
        chk("sr_excl", both_sr, 0);
        chk("done_err_excl", both_de, 0);
        chk("extra_accept", extra, 0);
        chk("ready_end", req_ready, 1);
        chk("level", level, level_m);
    endtask

    task automatic reset_mid_pulse();
        int n_de = 0;
        wait_ready();
        nbad_cur   = 0;
        pulse_seen = 0;
        req_valid  = 1'b1;
        req_level  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_s_before", S, 1);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_s", S, 0);
        chk("midrst_r", R, 0);
        chk("midrst_ready", req_ready, 1);
        chk("midrst_level", level, 0);
        rst_n   = 1'b1;
        level_m = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || err) n_de++;
        end
        chk("midrst_no_done_err", n_de, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_level = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s", S, 0);
        chk("rst_r", R, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", req_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1'b1, 0);
        run_txn(1'b0, 0);
        run_txn(1'b1, 3);
        run_txn(1'b1, 1);
        run_txn(1'b1, 0);
        run_txn(1'b1, 0);
        reset_mid_pulse();
        for (int i = 0; i < 20; i++) begin
            run_txn(1'($urandom), int'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rs_driver.md
RS_DRIVER -- requirements
Module: rs_driver

Interface
REQ-001 Parameter PULSE_W, default 2: number of cycles S or R is held high per write attempt, range 1..15.
REQ-002 Parameter SETTLE, default 1: number of idle cycles (S=R=0) between the end of a pulse and the Q_fb check, range 0..15.
REQ-003 Parameter MAX_TRY, default 3: number of pulse attempts before an error is flagged, range 1..7.
REQ-004 clk  input  1  single clock; all logic updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 req_valid  input  1  a write request is present.
REQ-007 req_level  input  1  target latch value: 1 = set, 0 = reset.
REQ-008 req_ready  output  1  the block can accept a request.
REQ-009 S  output  1  set drive to the gated RS latch.
REQ-010 R  output  1  reset drive to the gated RS latch.
REQ-011 Q_fb  input  1  latch Q output, fed back for confirmation.
REQ-012 done  output  1  one-cycle pulse: write confirmed.
REQ-013 err  output  1  one-cycle pulse: write failed after MAX_TRY attempts.
REQ-014 level  output  1  last confirmed latch value.

Function
REQ-015 The block SHALL have exactly these FSM states: IDLE, PULSE, SETTLE, CHECK.
REQ-016 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where req_valid=1 and req_ready=1, and req_level SHALL be captured on that edge.
REQ-017 Transitions: IDLE->PULSE on accept; PULSE->SETTLE after PULSE_W cycles (directly to CHECK if SETTLE=0); SETTLE->CHECK after SETTLE cycles; CHECK->IDLE on a match or on exhausted tries; CHECK->PULSE on a mismatch with tries remaining.
REQ-018 In PULSE, the block SHALL drive S=1,R=0 when the captured level is 1, and S=0,R=1 when it is 0; in every other state it SHALL drive S=R=0.
REQ-019 S and R SHALL never be 1 in the same cycle, including across reset and retry boundaries.
REQ-020 S, R, done, err, req_ready and level SHALL be registered outputs.
REQ-021 In CHECK, the block SHALL sample Q_fb once; if it equals the captured level, done SHALL be 1 for exactly the next cycle and level SHALL update to the captured value on that same edge.
REQ-022 On a mismatch, the try counter SHALL increment; if the count is less than MAX_TRY, the block SHALL re-enter PULSE with the same level.
REQ-023 On a mismatch when the count equals MAX_TRY, err SHALL be 1 for exactly the next cycle and level SHALL be left unchanged.
REQ-024 The try counter SHALL clear on every accept.
REQ-025 Latency with default parameters, for an accept at edge 0 and a first-try match: S/R high in cycles 1-2, settle in cycle 3, check in cycle 4, done=1 and req_ready=1 in cycle 5.
REQ-026 A request whose value equals the current level SHALL still be pulsed and checked, with no short-cut.
REQ-027 req_valid asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-028 done and err SHALL never both be 1 in the same cycle.

Reset
REQ-029 While rst_n=0 at a rising edge, the block SHALL go to IDLE with S=0, R=0, done=0, err=0, level=0, req_ready=1, and the try counter at 0.
REQ-030 A reset asserted mid-PULSE SHALL drop S/R to 0 on that edge; the aborted request SHALL produce neither done nor err.

Structure
REQ-031 Package rs_driver_pkg SHALL hold the state encoding and the default values of PULSE_W, SETTLE and MAX_TRY.
REQ-032 A sub-module rs_pulse_timer (a loadable down-counter with a zero flag) SHALL time both the PULSE and SETTLE phases.

Verification
REQ-033 Reset, then req_level=1 with a latch model attached -> S high for 2 cycles, done in cycle 5, level=1.
REQ-034 From level=1, req_level=0 -> R high for 2 cycles, S stays 0, done pulses, level=0.
REQ-035 Q_fb forced at 0 with req_level=1 -> 3 S pulses, err=1 for one cycle, level unchanged, done never asserted.
REQ-036 Q_fb wrong on the first check and correct on the second -> 2 S pulses, done=1, no err.
REQ-037 rst_n driven low in cycle 2 of PULSE -> S=R=0 on the next edge, req_ready=1, no done or err.
REQ-038 All runs -> the assertion "S and R are never both 1" SHALL hold, and req_valid held high during busy cycles SHALL produce exactly one transaction.
